// File: rtl/nap_countdown.sv
// nap_countdown: BCD M:SS countdown from a keypad-loaded duration, with a timed wake-up alarm
module nap_countdown #(
  parameter int TICK_DIV   = 1000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       completeSetting,
  input  logic [3:0] one_min,
  input  logic [3:0] ten_sec,
  input  logic [3:0] one_sec,
  input  logic       cancel,
  input  logic       alarm_ack,
  output logic [3:0] disp_min,
  output logic [3:0] disp_tsec,
  output logic [3:0] disp_sec,
  output logic       running,
  output logic       alarm
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(ALARM_SECS + 1);
  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;
  state_t        state;
  logic [PW-1:0] presc;
  logic [AW-1:0] acnt;
  logic          cs_q, load, tick, l_zero, n_zero;
  logic [3:0]    l_min, l_tsec, l_sec, n_min, n_tsec, n_sec;
  // load edge, prescaler tick, clamped load digits and the borrowed decrement
  always_comb begin
    load   = completeSetting & ~cs_q;
    tick   = presc == PW'(TICK_DIV - 1);
    l_min  = one_min > 4'd9 ? 4'd9 : one_min;
    l_tsec = ten_sec > 4'd5 ? 4'd5 : ten_sec;
    l_sec  = one_sec > 4'd9 ? 4'd9 : one_sec;
    l_zero = l_min == 4'd0 && l_tsec == 4'd0 && l_sec == 4'd0;
    n_sec  = disp_sec != 4'd0 ? disp_sec - 4'd1 : 4'd9;
    n_tsec = disp_sec != 4'd0 ? disp_tsec : (disp_tsec != 4'd0 ? disp_tsec - 4'd1 : 4'd5);
    n_min  = (disp_sec == 4'd0 && disp_tsec == 4'd0) ? disp_min - 4'd1 : disp_min;
    n_zero = n_min == 4'd0 && n_tsec == 4'd0 && n_sec == 4'd0;
  end
  // state machine: cancel beats load beats ack beats tick; cs_q resets high so a held level is not a load
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= '0;
      acnt      <= '0;
      cs_q      <= 1'b1;
      disp_min  <= '0;
      disp_tsec <= '0;
      disp_sec  <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      cs_q <= completeSetting;
      if ((cancel && state != IDLE) || (alarm_ack && state == ALARM && !load)) begin
        state     <= IDLE;
        presc     <= '0;
        acnt      <= '0;
        disp_min  <= '0;
        disp_tsec <= '0;
        disp_sec  <= '0;
        running   <= 1'b0;
        alarm     <= 1'b0;
      end else if (load) begin
        state     <= l_zero ? IDLE : RUN;
        presc     <= '0;
        acnt      <= '0;
        disp_min  <= l_min;
        disp_tsec <= l_tsec;
        disp_sec  <= l_sec;
        running   <= !l_zero;
        alarm     <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              disp_min  <= n_min;
              disp_tsec <= n_tsec;
              disp_sec  <= n_sec;
              if (n_zero) begin
                state   <= ALARM;
                acnt    <= '0;
                running <= 1'b0;
                alarm   <= 1'b1;
              end
            end
          end
          ALARM: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && acnt == AW'(ALARM_SECS - 1)) begin
              state <= IDLE;
              acnt  <= '0;
              alarm <= 1'b0;
            end else if (tick) acnt <= acnt + AW'(1);
          end
          default: begin
            presc <= '0;
            acnt  <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nap_countdown.sv
// tb_nap_countdown: directed checks of load, borrow, clamp, alarm exit, cancel and async reset
module tb_nap_countdown;
  logic       clock = 1'b0, reset = 1'b0, completeSetting = 1'b0, cancel = 1'b0, alarm_ack = 1'b0;
  logic [3:0] one_min = '0, ten_sec = '0, one_sec = '0;
  logic [3:0] disp_min, disp_tsec, disp_sec;
  logic       running, alarm;
  int         n_cmp = 0, n_err = 0;

  nap_countdown #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
    .clock(clock), .reset(reset), .completeSetting(completeSetting),
    .one_min(one_min), .ten_sec(ten_sec), .one_sec(one_sec),
    .cancel(cancel), .alarm_ack(alarm_ack),
    .disp_min(disp_min), .disp_tsec(disp_tsec), .disp_sec(disp_sec),
    .running(running), .alarm(alarm)
  );

  always #5 clock = ~clock;

  // observation word: M, T, S digits then {2'b0, running, alarm}
  function automatic logic [15:0] obs();
    return {disp_min, disp_tsec, disp_sec, 2'b00, running, alarm};
  endfunction

  // one idle cycle, then a rising completeSetting sampled at the next edge; returns just after it
  task automatic load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] s);
    @(negedge clock);
    one_min = m; ten_sec = t; one_sec = s; completeSetting = 1'b1;
    @(negedge clock);
    completeSetting = 1'b0;
  endtask

  task automatic test_reset();
    completeSetting = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL reset_state got %h exp %h", obs(), 16'h0000); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL held_cs_no_load got %h exp %h", obs(), 16'h0000); end
    completeSetting = 1'b0;
  endtask

  task automatic test_basic_and_timeout();
    load(4'd0, 4'd0, 4'd5);
    n_cmp++; if (obs() !== 16'h0052) begin n_err++; $display("FAIL basic_load got %h exp %h", obs(), 16'h0052); end
    repeat (4) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0042) begin n_err++; $display("FAIL basic_tick got %h exp %h", obs(), 16'h0042); end
    repeat (15) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0012) begin n_err++; $display("FAIL basic_pre_alarm got %h exp %h", obs(), 16'h0012); end
    @(negedge clock);
    n_cmp++; if (obs() !== 16'h0001) begin n_err++; $display("FAIL basic_alarm got %h exp %h", obs(), 16'h0001); end
    repeat (11) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0001) begin n_err++; $display("FAIL alarm_hold got %h exp %h", obs(), 16'h0001); end
    @(negedge clock);
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL alarm_timeout got %h exp %h", obs(), 16'h0000); end
  endtask

  task automatic test_borrow();
    load(4'd1, 4'd0, 4'd0);
    n_cmp++; if (obs() !== 16'h1002) begin n_err++; $display("FAIL borrow_load100 got %h exp %h", obs(), 16'h1002); end
    repeat (4) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0592) begin n_err++; $display("FAIL borrow_059 got %h exp %h", obs(), 16'h0592); end
    load(4'd0, 4'd3, 4'd0);
    n_cmp++; if (obs() !== 16'h0302) begin n_err++; $display("FAIL borrow_load030 got %h exp %h", obs(), 16'h0302); end
    repeat (4) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0292) begin n_err++; $display("FAIL borrow_029 got %h exp %h", obs(), 16'h0292); end
    repeat (36) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0202) begin n_err++; $display("FAIL borrow_020 got %h exp %h", obs(), 16'h0202); end
    repeat (4) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0192) begin n_err++; $display("FAIL borrow_019 got %h exp %h", obs(), 16'h0192); end
    repeat (36) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0102) begin n_err++; $display("FAIL borrow_010 got %h exp %h", obs(), 16'h0102); end
    repeat (4) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0092) begin n_err++; $display("FAIL borrow_009 got %h exp %h", obs(), 16'h0092); end
  endtask

  task automatic test_clamp();
    load(4'd12, 4'd7, 4'd11);
    n_cmp++; if (obs() !== 16'h9592) begin n_err++; $display("FAIL clamp_959 got %h exp %h", obs(), 16'h9592); end
    load(4'd0, 4'd0, 4'd0);
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL clamp_zero_idle got %h exp %h", obs(), 16'h0000); end
  endtask

  task automatic test_ack();
    load(4'd0, 4'd0, 4'd1);
    n_cmp++; if (obs() !== 16'h0012) begin n_err++; $display("FAIL ack_load got %h exp %h", obs(), 16'h0012); end
    repeat (4) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0001) begin n_err++; $display("FAIL ack_alarm_entry got %h exp %h", obs(), 16'h0001); end
    repeat (2) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0001) begin n_err++; $display("FAIL ack_alarm_hold got %h exp %h", obs(), 16'h0001); end
    alarm_ack = 1'b1;
    @(negedge clock);
    alarm_ack = 1'b0;
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL ack_exit got %h exp %h", obs(), 16'h0000); end
  endtask

  task automatic test_cancel();
    load(4'd0, 4'd0, 4'd5);
    repeat (8) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0032) begin n_err++; $display("FAIL cancel_at_003 got %h exp %h", obs(), 16'h0032); end
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL cancel_run got %h exp %h", obs(), 16'h0000); end
    load(4'd0, 4'd0, 4'd5);
    n_cmp++; if (obs() !== 16'h0052) begin n_err++; $display("FAIL cancel_reload got %h exp %h", obs(), 16'h0052); end
    @(negedge clock);
    one_sec = 4'd7; completeSetting = 1'b1; cancel = 1'b1;
    @(negedge clock);
    completeSetting = 1'b0; cancel = 1'b0;
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL cancel_beats_load got %h exp %h", obs(), 16'h0000); end
  endtask

  task automatic test_async_reset();
    load(4'd0, 4'd0, 4'd5);
    n_cmp++; if (obs() !== 16'h0052) begin n_err++; $display("FAIL areset_load got %h exp %h", obs(), 16'h0052); end
    #2 reset = 1'b0; completeSetting = 1'b1;
    #1;
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL areset_no_clock got %h exp %h", obs(), 16'h0000); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++; if (obs() !== 16'h0000) begin n_err++; $display("FAIL areset_held_cs got %h exp %h", obs(), 16'h0000); end
    completeSetting = 1'b0;
    load(4'd0, 4'd0, 4'd2);
    n_cmp++; if (obs() !== 16'h0022) begin n_err++; $display("FAIL areset_reload got %h exp %h", obs(), 16'h0022); end
  endtask

  initial begin
    test_reset();
    test_basic_and_timeout();
    test_borrow();
    test_clamp();
    test_ack();
    test_cancel();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
